masked_cumsum_stream: RTL and testbench

- Streaming, multi-lane masked cumulative sum: each accepted beat carries LANES signed elements plus a per-lane mask.
- Output is the running sum of unmasked elements across the beats of a row. A row is delimited by in_last.
- Successor to the single-word masked-cumsum operator block. Adds lane parallelism, row segmentation, valid/ready backpressure, inclusive/exclusive mode and optional saturation.
- Sits in the operator datapath between the tensor streamer and the writeback stage.

---
 rtl/masked_cumsum_stream_if.sv | 30 +++
 rtl/masked_cumsum_stream.sv | 125 ++++++++++++
 tb/tb_masked_cumsum_stream.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/masked_cumsum_stream_if.sv
// Stream bundle for masked_cumsum_stream: input beat, output beat and the
// per-row mode select. The master drives beats in and drains results; the
// slave is the accumulator block.
interface masked_cumsum_stream_if #(
    parameter int LANES = 4,
    parameter int DW    = 32,
    parameter int AW    = 40
);
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*DW-1:0]   in_data;
    logic [LANES-1:0]      in_mask;
    logic                  in_last;
    logic                  cfg_exclusive;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*AW-1:0]   out_data;
    logic                  out_last;
    logic                  out_sat;

    modport master (
        output in_valid, in_data, in_mask, in_last, cfg_exclusive, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_mask, in_last, cfg_exclusive, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sat
    );
endinterface

// File: rtl/masked_cumsum_stream.sv
// Streaming multi-lane masked cumulative sum. Each accepted beat adds its
// unmasked lanes (lane 0 first) onto the row accumulator; in_last closes the
// row. One output register stage gives 1-cycle latency at full throughput.
module masked_cumsum_stream #(
    parameter int LANES    = 4,
    parameter int DW       = 32,
    parameter int AW       = 40,
    parameter int SATURATE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    masked_cumsum_stream_if.slave   io_bus
);

    localparam logic [AW-1:0] SMAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] SMIN = {1'b1, {(AW-1){1'b0}}};

    // Sign-extend one DW-bit element to accumulator width.
    function automatic logic [AW-1:0] sext(input logic [DW-1:0] d);
        logic signed [DW-1:0] t;
        logic signed [AW-1:0] r;
        t = d;
        r = t;
        return r;
    endfunction

    // One chain step: returns {clamp_flag, sum}. Wraps unless SATURATE.
    function automatic logic [AW:0] add_lane(input logic [AW-1:0] a,
                                             input logic [AW-1:0] b);
        logic [AW:0] s;
        s = {a[AW-1], a} + {b[AW-1], b};
        if ((SATURATE != 0) && (s[AW] != s[AW-1])) begin
            return {1'b1, (s[AW] ? SMIN : SMAX)};
        end else begin
            return {1'b0, s[AW-1:0]};
        end
    endfunction

    logic [AW-1:0]       r_acc;
    logic                r_mode;
    logic                r_sor;
    logic                r_sticky;
    logic                r_out_valid;
    logic [LANES*AW-1:0] r_out_data;
    logic                r_out_last;
    logic                r_out_sat;

    logic [AW-1:0]       w_run [0:LANES];
    logic [AW-1:0]       w_elem [0:LANES-1];
    logic [AW:0]         w_sum [0:LANES-1];
    logic [LANES*AW-1:0] w_out;
    logic                w_clamp;
    logic                w_mode;
    logic                w_in_ready;
    logic                w_accept;

    // The mode register only follows cfg_exclusive on a row's first beat.
    assign w_mode     = r_sor ? io_bus.cfg_exclusive : r_mode;
    assign w_in_ready = !rst && (!r_out_valid || io_bus.out_ready);
    assign w_accept   = io_bus.in_valid && w_in_ready;

    // Running-sum chain across the lanes plus the per-lane output select.
    always_comb begin
        w_run[0] = r_acc;
        w_clamp  = 1'b0;
        w_out    = {(LANES*AW){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (io_bus.in_mask[i]) begin
                w_elem[i] = sext(io_bus.in_data[i*DW +: DW]);
            end else begin
                w_elem[i] = {AW{1'b0}};
            end
            w_sum[i]     = add_lane(w_run[i], w_elem[i]);
            w_run[i+1]   = w_sum[i][AW-1:0];
            w_clamp      = w_clamp | w_sum[i][AW];
        end
        for (int i = 0; i < LANES; i++) begin
            if (w_mode) begin
                w_out[i*AW +: AW] = w_run[i];
            end else begin
                w_out[i*AW +: AW] = w_run[i+1];
            end
        end
    end

    // Row state and output register: load on accept, drain on transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= {AW{1'b0}};
            r_mode      <= 1'b0;
            r_sor       <= 1'b1;
            r_sticky    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= {(LANES*AW){1'b0}};
            r_out_last  <= 1'b0;
            r_out_sat   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_out;
            r_out_last  <= io_bus.in_last;
            r_out_sat   <= r_sticky | w_clamp;
            r_mode      <= w_mode;
            if (io_bus.in_last) begin
                r_acc    <= {AW{1'b0}};
                r_sticky <= 1'b0;
                r_sor    <= 1'b1;
            end else begin
                r_acc    <= w_run[LANES];
                r_sticky <= r_sticky | w_clamp;
                r_sor    <= 1'b0;
            end
        end else if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.out_last  = r_out_last;
    assign io_bus.out_sat   = r_out_sat;

endmodule

// File: tb/tb_masked_cumsum_stream.sv
// Directed bench for masked_cumsum_stream: a default-width instance for
// masking, row carry, mode latch, backpressure and reset, plus two 8-bit
// instances (saturating and wrapping) driven with the same beats.
module tb_masked_cumsum_stream;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    masked_cumsum_stream_if #(.LANES(4), .DW(32), .AW(40)) ba ();
    masked_cumsum_stream_if #(.LANES(4), .DW(8),  .AW(8))  sb ();
    masked_cumsum_stream_if #(.LANES(4), .DW(8),  .AW(8))  wb ();

    masked_cumsum_stream #(.LANES(4), .DW(32), .AW(40), .SATURATE(0)) u_a (
        .clk(clk), .rst(rst), .io_bus(ba));
    masked_cumsum_stream #(.LANES(4), .DW(8), .AW(8), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .io_bus(sb));
    masked_cumsum_stream #(.LANES(4), .DW(8), .AW(8), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .io_bus(wb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input int d0, input int d1, input int d2, input int d3,
                           input logic [3:0] m, input logic last, input logic excl);
        ba.in_valid      = 1'b1;
        ba.in_data       = {d3, d2, d1, d0};
        ba.in_mask       = m;
        ba.in_last       = last;
        ba.cfg_exclusive = excl;
    endtask

    task automatic check_a(input string tag, input longint e0, input longint e1,
                           input longint e2, input longint e3, input logic last);
        logic [63:0] exp [4];
        exp[0] = 64'(e0); exp[1] = 64'(e1); exp[2] = 64'(e2); exp[3] = 64'(e3);
        check_val({tag, "_valid"}, 64'(ba.out_valid), 64'd1);
        check_val({tag, "_last"}, 64'(ba.out_last), 64'(last));
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("%s_l%0d", tag, i), 64'(ba.out_data[i*40 +: 40]), exp[i]);
        end
    endtask

    task automatic drive_s(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic last);
        sb.in_valid = 1'b1; sb.in_data = {b3, b2, b1, b0}; sb.in_mask = 4'hF;
        sb.in_last = last;  sb.cfg_exclusive = 1'b0;
        wb.in_valid = 1'b1; wb.in_data = {b3, b2, b1, b0}; wb.in_mask = 4'hF;
        wb.in_last = last;  wb.cfg_exclusive = 1'b0;
    endtask

    task automatic check8(input string tag, input logic [31:0] obs, input logic obs_sat,
                          input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                          input logic [7:0] e3, input logic esat);
        logic [31:0] exp;
        exp = {e3, e2, e1, e0};
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("%s_l%0d", tag, i), 64'(obs[i*8 +: 8]), 64'(exp[i*8 +: 8]));
        end
        check_val({tag, "_sat"}, 64'(obs_sat), 64'(esat));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        ba.in_valid = 1'b0; ba.in_data = '0; ba.in_mask = '0; ba.in_last = 1'b0;
        ba.cfg_exclusive = 1'b0; ba.out_ready = 1'b1;
        sb.in_valid = 1'b0; sb.in_data = '0; sb.in_mask = '0; sb.in_last = 1'b0;
        sb.cfg_exclusive = 1'b0; sb.out_ready = 1'b1;
        wb.in_valid = 1'b0; wb.in_data = '0; wb.in_mask = '0; wb.in_last = 1'b0;
        wb.cfg_exclusive = 1'b0; wb.out_ready = 1'b1;

        // Reset state
        step();
        step();
        check_val("rst_out_valid", 64'(ba.out_valid), 64'd0);
        check_val("rst_out_last", 64'(ba.out_last), 64'd0);
        check_val("rst_out_sat", 64'(ba.out_sat), 64'd0);
        check_val("rst_out_data_lo", ba.out_data[63:0], 64'd0);
        check_val("rst_out_data_hi", 64'(ba.out_data[159:64]), 64'd0);
        check_val("rst_in_ready", 64'(ba.in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check_val("idle_in_ready", 64'(ba.in_ready), 64'd1);

        // Masked inclusive / exclusive single-beat rows
        drive_a(1, 2, 3, 4, 4'b1101, 1'b1, 1'b0); step();
        check_a("mask_incl", 1, 1, 4, 8, 1'b1);
        drive_a(1, 2, 3, 4, 4'b1101, 1'b1, 1'b1); step();
        check_a("mask_excl", 0, 1, 1, 4, 1'b1);

        // Row carry and clearing
        drive_a(1, 1, 1, 1, 4'hF, 1'b0, 1'b0); step();
        check_a("row_b0", 1, 2, 3, 4, 1'b0);
        drive_a(2, 2, 2, 2, 4'hF, 1'b1, 1'b0); step();
        check_a("row_b1", 6, 8, 10, 12, 1'b1);
        drive_a(5, 0, 0, 0, 4'hF, 1'b1, 1'b0); step();
        check_a("row_new", 5, 5, 5, 5, 1'b1);

        // Mode latched at row start
        drive_a(1, 1, 1, 1, 4'hF, 1'b0, 1'b0); step();
        check_a("mode_b0", 1, 2, 3, 4, 1'b0);
        drive_a(1, 1, 1, 1, 4'hF, 1'b1, 1'b1); step();
        check_a("mode_b1", 5, 6, 7, 8, 1'b1);
        drive_a(1, 1, 1, 1, 4'hF, 1'b1, 1'b1); step();
        check_a("mode_next", 0, 1, 2, 3, 1'b1);

        // All-zero mask keeps the accumulator
        drive_a(3, 0, 0, 0, 4'hF, 1'b0, 1'b0); step();
        check_a("zm_b0", 3, 3, 3, 3, 1'b0);
        drive_a(9, 9, 9, 9, 4'h0, 1'b1, 1'b0); step();
        check_a("zm_b1", 3, 3, 3, 3, 1'b1);

        // Backpressure: three beats, output stalled three cycles after the first
        drive_a(1, 1, 1, 1, 4'hF, 1'b0, 1'b0); step();
        check_a("bp_a", 1, 2, 3, 4, 1'b0);
        ba.out_ready = 1'b0;
        drive_a(2, 0, 0, 0, 4'hF, 1'b0, 1'b0);
        #1;
        for (int c = 0; c < 3; c++) begin
            check_val($sformatf("bp_stall%0d_in_ready", c), 64'(ba.in_ready), 64'd0);
            step();
            check_a($sformatf("bp_stall%0d", c), 1, 2, 3, 4, 1'b0);
        end
        ba.out_ready = 1'b1;
        #1;
        check_val("bp_release_in_ready", 64'(ba.in_ready), 64'd1);
        step();
        check_a("bp_b", 6, 6, 6, 6, 1'b0);
        drive_a(0, 0, 0, 1, 4'hF, 1'b1, 1'b0); step();
        check_a("bp_c", 6, 6, 6, 7, 1'b1);
        ba.in_valid = 1'b0;
        step();
        check_val("bp_drain_valid", 64'(ba.out_valid), 64'd0);

        // Reset mid-row drops the partial row and pending output
        drive_a(1, 1, 1, 1, 4'hF, 1'b0, 1'b0); step();
        check_a("mr_pre", 1, 2, 3, 4, 1'b0);
        ba.in_valid = 1'b0;
        rst = 1'b1;
        step();
        check_val("mr_valid", 64'(ba.out_valid), 64'd0);
        rst = 1'b0;
        drive_a(1, 1, 1, 1, 4'hF, 1'b1, 1'b0); step();
        check_a("mr_post", 1, 2, 3, 4, 1'b1);
        ba.in_valid = 1'b0;

        // Saturating vs wrapping 8-bit instances
        drive_s(8'd100, 8'd100, 8'hCE, 8'd0, 1'b1); step();
        check8("sat_r0", sb.out_data, sb.out_sat, 8'h64, 8'h7F, 8'h4D, 8'h4D, 1'b1);
        check8("wrap_r0", wb.out_data, wb.out_sat, 8'h64, 8'hC8, 8'h96, 8'h96, 1'b0);
        drive_s(8'd1, 8'd0, 8'd0, 8'd0, 1'b1); step();
        check8("sat_r1", sb.out_data, sb.out_sat, 8'h01, 8'h01, 8'h01, 8'h01, 1'b0);
        check8("wrap_r1", wb.out_data, wb.out_sat, 8'h01, 8'h01, 8'h01, 8'h01, 1'b0);
        drive_s(8'd127, 8'd1, 8'd0, 8'd0, 1'b0); step();
        check8("sat_r2b0", sb.out_data, sb.out_sat, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b1);
        check8("wrap_r2b0", wb.out_data, wb.out_sat, 8'h7F, 8'h80, 8'h80, 8'h80, 1'b0);
        drive_s(8'hFF, 8'd0, 8'd0, 8'd0, 1'b1); step();
        check8("sat_r2b1", sb.out_data, sb.out_sat, 8'h7E, 8'h7E, 8'h7E, 8'h7E, 1'b1);
        check8("wrap_r2b1", wb.out_data, wb.out_sat, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b0);
        drive_s(8'h80, 8'hFF, 8'd5, 8'd0, 1'b1); step();
        check8("sat_r3", sb.out_data, sb.out_sat, 8'h80, 8'h80, 8'h85, 8'h85, 1'b1);
        check8("wrap_r3", wb.out_data, wb.out_sat, 8'h80, 8'h7F, 8'h84, 8'h84, 1'b0);
        sb.in_valid = 1'b0;
        wb.in_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
